// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline defaults and the fetch entry record
//
// Purpose : default widths and the NOP encoding used by the fetch stage,
//           plus the {pc, instr} record carried from fetch to decode.
// Ports   : none (package)
package pipeline_pkg;

  localparam int FETCH_PC_W    = 32;
  localparam int FETCH_INSTR_W = 32;

  // addi x0,x0,0 -- presented to decode whenever the queue is empty
  localparam logic [FETCH_INSTR_W-1:0] FETCH_NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_PC_W-1:0]    pc;
    logic [FETCH_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - generic synchronous show-ahead FIFO with flush
//
// Purpose : small FIFO whose head entry is always visible on rdata.
//           flush clears occupancy and pointers and wins over push/pop.
// Ports   : clk    in   rising-edge clock
//           rst_n  in   asynchronous active-low reset
//           push   in   write wdata at the tail this cycle
//           wdata  in   WIDTH  data to write
//           pop    in   drop the head entry this cycle (ignored when empty)
//           flush  in   synchronous clear, highest priority
//           rdata  out  WIDTH  head entry (stale when empty)
//           occ    out  number of stored entries, 0..DEPTH
//           full   out  occ == DEPTH
//           empty  out  occ == 0
module fetch_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int OW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rdata,
  output logic [OW-1:0]    occ,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic             do_push, do_pop;

  assign empty = (occ_q == '0);
  assign full  = (occ_q == OW'(DEPTH));
  assign occ   = occ_q;
  assign rdata = mem_q[rd_ptr_q];

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      // DEPTH is a power of two, so pointer wrap is the natural AW-bit overflow
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      occ_d = occ_q + 1'b1;
      else if (do_pop && !do_push) occ_d = occ_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage needs no reset: nothing reads an entry before it is written,
  // and the top level masks rdata while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/if_fetch_buffer.sv
// rtl/if_fetch_buffer.sv - instruction fetch stage with credit-based fetch queue
//
// Purpose : issues an imem read for each accepted PC, captures the reply one
//           cycle later into a show-ahead queue, and presents {pc, instr} to
//           decode. A taken-branch flush drops queued and in-flight fetches.
// Ports   : clk         in   rising-edge clock
//           rst         in   asynchronous active-low reset
//           pc_in       in   PC_W     fetch PC from PC_adder
//           pc_valid    in   pc_in is a fetch request
//           pc_stall    out  request not accepted, PC_adder holds pc_in
//           imem_req    out  imem read strobe
//           imem_addr   out  PC_W     word-aligned read address
//           imem_rdata  in   INSTR_W  read data, valid the cycle after imem_req
//           flush       in   drop everything (taken branch)
//           id_valid    out  head entry valid toward decode
//           id_ready    in   decode accepts the head entry
//           id_pc       out  PC_W     head PC (0 when empty)
//           id_instr    out  INSTR_W  head instruction (NOP_INSTR when empty)
module if_fetch_buffer
  import pipeline_pkg::*;
#(
  parameter int                 DEPTH     = 4,
  parameter int                 PC_W      = FETCH_PC_W,
  parameter int                 INSTR_W   = FETCH_INSTR_W,
  parameter logic [INSTR_W-1:0] NOP_INSTR = FETCH_NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_W-1:0]    pc_in,
  input  logic               pc_valid,
  output logic               pc_stall,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               flush,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [PC_W-1:0]    id_pc,
  output logic [INSTR_W-1:0] id_instr
);

  localparam int ENTRY_W = PC_W + INSTR_W;
  localparam int OW      = $clog2(DEPTH + 1);

  logic               inflight_v_q, inflight_v_d;
  logic [PC_W-1:0]    inflight_pc_q, inflight_pc_d;

  logic [ENTRY_W-1:0] fifo_rdata;
  logic [OW-1:0]      fifo_occ;
  logic               fifo_full, fifo_empty;
  logic               fifo_push, fifo_pop;

  logic [OW:0]        pending;
  logic               credit;
  logic               fire;

  // Reserve a slot for the read already in flight; a same-cycle pop gives no
  // credit so the stall path never depends on id_ready.
  assign pending  = {1'b0, fifo_occ} + {{OW{1'b0}}, inflight_v_q};
  assign credit   = (pending < (OW + 1)'(DEPTH));
  assign pc_stall = !credit;

  assign fire      = pc_valid && credit && !flush;
  // Gated by rst so the strobe drops the moment reset is asserted.
  assign imem_req  = fire && rst;
  assign imem_addr = {pc_in[PC_W-1:2], 2'b00};

  always_comb begin
    inflight_v_d  = fire;
    inflight_pc_d = inflight_pc_q;
    if (fire) inflight_pc_d = pc_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_v_q  <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      inflight_v_q  <= inflight_v_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  // Credit already prevents overflow; the full term keeps the queue safe
  // even if that invariant were ever broken.
  assign fifo_pop  = id_valid && id_ready && !flush;
  assign fifo_push = inflight_v_q && !flush && (!fifo_full || fifo_pop);

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (fifo_push),
    .wdata ({inflight_pc_q, imem_rdata}),
    .pop   (fifo_pop),
    .flush (flush),
    .rdata (fifo_rdata),
    .occ   (fifo_occ),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Stale storage is never exposed: empty forces the idle values.
  assign id_valid = !fifo_empty;
  assign id_pc    = fifo_empty ? '0        : fifo_rdata[ENTRY_W-1:INSTR_W];
  assign id_instr = fifo_empty ? NOP_INSTR : fifo_rdata[INSTR_W-1:0];

endmodule

// File: tb/tb_if_fetch_buffer.sv
// tb/tb_if_fetch_buffer.sv - self-checking bench for if_fetch_buffer
module tb_if_fetch_buffer;
  import pipeline_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_in = '0;
  logic        pc_valid = 1'b0;
  logic        pc_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        flush = 1'b0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_pc;
  logic [31:0] id_instr;

  int total = 0;
  int bad   = 0;

  if_fetch_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .pc_in      (pc_in),
    .pc_valid   (pc_valid),
    .pc_stall   (pc_stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .flush      (flush),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_pc      (id_pc),
    .id_instr   (id_instr)
  );

  always #5 clk = ~clk;

  // Instruction memory: 1-cycle latency, word at address a holds 0xA0 + a.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= 32'hA0 + imem_addr;
  end

  typedef struct {
    logic        rst;
    logic        pv;
    logic [31:0] pc;
    logic        fl;
    logic        rdy;
    logic        req;
    logic        stall;
    logic        vld;
    logic [31:0] idpc;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] exp_instr(input logic [31:0] p);
    return 32'hA0 + {p[31:2], 2'b00};
  endfunction

  task automatic add(input logic r, input logic pv, input logic [31:0] p, input logic f,
                     input logic rd, input logic rq, input logic st, input logic vl,
                     input logic [31:0] ip);
    vec_t v;
    v.rst = r; v.pv = pv; v.pc = p; v.fl = f; v.rdy = rd;
    v.req = rq; v.stall = st; v.vld = vl; v.idpc = ip;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%h want=%h", name, idx, act, exp);
    end
  endtask

  logic [31:0] got_q[$];
  int          issued;
  logic        acc;
  logic        saw_stall;

  initial begin
    // reset (held low 2 cycles) then release
    add(0,0,0,0,0, 0,0,0,0);
    add(0,0,0,0,0, 0,0,0,0);
    add(1,0,0,0,0, 0,0,0,0);
    // streaming, id_ready=1
    add(1,1,0,0,1,  1,0,0,0);
    add(1,1,4,0,1,  1,0,0,0);
    add(1,1,8,0,1,  1,0,1,0);
    add(1,1,12,0,1, 1,0,1,4);
    add(1,0,0,0,1,  0,0,1,8);
    add(1,0,0,0,1,  0,0,1,12);
    add(1,0,0,0,1,  0,0,0,0);
    // backpressure: 4 held, stall until a slot frees (pop gives no same-cycle credit)
    add(1,1,0,0,0,  1,0,0,0);
    add(1,1,4,0,0,  1,0,0,0);
    add(1,1,8,0,0,  1,0,1,0);
    add(1,1,12,0,0, 1,0,1,0);
    add(1,1,16,0,0, 0,1,1,0);
    add(1,1,16,0,0, 0,1,1,0);
    add(1,1,16,0,1, 0,1,1,0);
    add(1,1,16,0,1, 1,0,1,4);
    add(1,1,20,0,1, 1,0,1,8);
    add(1,0,0,0,1,  0,0,1,12);
    add(1,0,0,0,1,  0,0,1,16);
    add(1,0,0,0,1,  0,0,1,20);
    add(1,0,0,0,1,  0,0,0,0);
    // flush with a read in flight; first PC after flush fetched normally
    add(1,1,32'h10,0,1, 1,0,0,0);
    add(1,0,0,1,1,      0,0,0,0);
    add(1,1,32'h40,0,1, 1,0,0,0);
    add(1,0,0,0,1,      0,0,0,0);
    add(1,0,0,0,1,      0,0,1,32'h40);
    add(1,0,0,0,1,      0,0,0,0);
    // flush with queue nearly full: stall from pre-flush state, no issue
    add(1,1,0,0,0,  1,0,0,0);
    add(1,1,4,0,0,  1,0,0,0);
    add(1,1,8,0,0,  1,0,1,0);
    add(1,1,12,0,0, 1,0,1,0);
    add(1,1,16,1,1, 0,1,1,0);
    add(1,1,16,0,1, 1,0,0,0);
    add(1,0,0,0,1,  0,0,0,0);
    add(1,0,0,0,1,  0,0,1,16);
    add(1,0,0,0,1,  0,0,0,0);
    // misaligned PC: address aligned, id_pc keeps low bits
    add(1,1,32'h22,0,1, 1,0,0,0);
    add(1,0,0,0,1,      0,0,0,0);
    add(1,0,0,0,1,      0,0,1,32'h22);
    add(1,0,0,0,1,      0,0,0,0);
    // simultaneous push/pop at occ=3 with a read in flight
    add(1,1,0,0,0,  1,0,0,0);
    add(1,1,4,0,0,  1,0,0,0);
    add(1,1,8,0,0,  1,0,1,0);
    add(1,1,12,0,0, 1,0,1,0);
    add(1,1,16,0,1, 0,1,1,0);
    add(1,1,16,0,1, 1,0,1,4);
    add(1,0,0,0,1,  0,0,1,8);
    add(1,0,0,0,1,  0,0,1,12);
    add(1,0,0,0,1,  0,0,1,16);
    add(1,0,0,0,1,  0,0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      rst      = vecs[i].rst;
      pc_valid = vecs[i].pv;
      pc_in    = vecs[i].pc;
      flush    = vecs[i].fl;
      id_ready = vecs[i].rdy;
      @(negedge clk);
      chk("imem_req", i, {31'b0, imem_req}, {31'b0, vecs[i].req});
      chk("pc_stall", i, {31'b0, pc_stall}, {31'b0, vecs[i].stall});
      chk("id_valid", i, {31'b0, id_valid}, {31'b0, vecs[i].vld});
      chk("id_pc", i, id_pc, vecs[i].vld ? vecs[i].idpc : 32'h0);
      chk("id_instr", i, id_instr, vecs[i].vld ? exp_instr(vecs[i].idpc) : NOP);
      if (vecs[i].req) chk("imem_addr", i, imem_addr, {vecs[i].pc[31:2], 2'b00});
    end

    // PC_adder model: pc advances only when accepted; decode blocked early.
    @(posedge clk); #1;
    pc_valid = 1'b0; flush = 1'b0; id_ready = 1'b0; pc_in = 32'h0;
    issued = 0; acc = 1'b0; saw_stall = 1'b0;
    for (int c = 0; c < 200 && got_q.size() < 6; c++) begin
      @(posedge clk); #1;
      if (acc) begin
        issued++;
        pc_in = pc_in + 32'd4;
      end
      pc_valid = (issued < 6);
      id_ready = (c >= 8);
      @(negedge clk);
      acc = pc_valid && !pc_stall;
      if (pc_stall) saw_stall = 1'b1;
      if (id_valid && id_ready) begin
        got_q.push_back(id_pc);
        chk("stream_instr", c, id_instr, exp_instr(id_pc));
      end
    end
    chk("stream_count", 0, got_q.size(), 6);
    chk("stream_stalled", 0, {31'b0, saw_stall}, 32'd1);
    for (int k = 0; k < got_q.size() && k < 6; k++)
      chk("stream_order", k, got_q[k], 32'(4 * k));

    // async reset mid-stream with occ=2 and a request on the bus
    @(posedge clk); #1;
    pc_valid = 1'b1; pc_in = 32'h0; id_ready = 1'b0;
    @(posedge clk); #1; pc_in = 32'h4;
    @(posedge clk); #1; pc_in = 32'h8;
    @(posedge clk); #1; pc_in = 32'hC;
    #2;
    chk("pre_rst_valid", 0, {31'b0, id_valid}, 32'd1);
    chk("pre_rst_req", 0, {31'b0, imem_req}, 32'd1);
    rst = 1'b0;
    #1;
    chk("async_valid", 0, {31'b0, id_valid}, 32'd0);
    chk("async_req", 0, {31'b0, imem_req}, 32'd0);
    chk("async_stall", 0, {31'b0, pc_stall}, 32'd0);
    chk("async_pc", 0, id_pc, 32'h0);
    chk("async_instr", 0, id_instr, NOP);
    pc_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1; pc_valid = 1'b1; pc_in = 32'h0; id_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_req", 0, {31'b0, imem_req}, 32'd1);
    @(posedge clk); #1; pc_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_early", 0, {31'b0, id_valid}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_valid", 0, {31'b0, id_valid}, 32'd1);
    chk("post_rst_pc", 0, id_pc, 32'h0);
    chk("post_rst_instr", 0, id_instr, 32'hA0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
